// File: rtl/enc_quad_gen.sv
// enc_quad_gen: register-commanded quadrature A/B generator; index output when ENC_GEN_INDEX_EN is defined
module enc_quad_gen #(
  parameter logic [3:0] ADDR_SPACE = 4'h0,
  parameter logic [3:0] CHAN = 4'h5,
  parameter int IDX_BITS = 12
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] reg_raddr,
  output logic [31:0] reg_rdata,
  input  logic [15:0] reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wen,
  output logic        enc_a,
  output logic        enc_b,
  output logic        enc_i,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, CONT} state_t;
  state_t state, state_nx;
  logic [23:0] period, remaining, pos, timer, wval, steps_mag, pos_nx;
  logic [1:0] phase, phase_nx;
  logic [3:0] roff;
  logic dir, cont_mode, wsel, rsel, we_perd, we_steps, we_ctrl, we_pos, abort, step;
  logic unused_ok;
  assign wval = reg_wdata[23:0];
  assign wsel = reg_wen && reg_waddr[15:12] == ADDR_SPACE && reg_waddr[7:4] == CHAN;
  assign rsel = reg_raddr[15:12] == ADDR_SPACE && reg_raddr[7:4] == CHAN;
  assign roff = reg_raddr[3:0];
  assign we_perd = wsel && reg_waddr[3:0] == 4'd0;
  assign we_steps = wsel && reg_waddr[3:0] == 4'd1;
  assign we_ctrl = wsel && reg_waddr[3:0] == 4'd2;
  assign we_pos = wsel && reg_waddr[3:0] == 4'd3;
  assign abort = we_ctrl && reg_wdata[0];
  assign steps_mag = wval[23] ? -wval : wval;
  assign busy = state != IDLE;
  assign step = busy && timer == 24'd0 && !we_steps && !abort;
  assign phase_nx = step ? (dir ? phase - 2'd1 : phase + 2'd1) : phase;
  assign pos_nx = we_pos ? wval : step ? (dir ? pos - 24'd1 : pos + 24'd1) : pos;
  assign unused_ok = ^{reg_raddr[11:8], reg_waddr[11:8], reg_wdata[31:24], IDX_BITS != 0};
  always_comb
    state_nx = abort ? IDLE :
               we_steps ? (wval == 24'd0 ? IDLE : cont_mode ? CONT : RUN) :
               (step && state == RUN && remaining == 24'd1) ? IDLE : state;
  always_comb
    reg_rdata = !rsel ? 32'd0 :
                roff == 4'd0 ? {8'd0, period} :
                roff == 4'd1 ? {{8{remaining[23]}}, remaining} :
                roff == 4'd2 ? {24'd0, busy, cont_mode, dir, phase, enc_i, enc_a, enc_b} :
                roff == 4'd3 ? {8'd0, pos} : 32'd0;
  always_ff @(posedge sysclk)
    if (reset) begin
      state <= IDLE;
      period <= 24'd2;
      remaining <= '0;
      pos <= '0;
      timer <= '0;
      phase <= '0;
      dir <= 1'b0;
      cont_mode <= 1'b0;
      enc_a <= 1'b0;
      enc_b <= 1'b0;
    end else begin
      state <= state_nx;
      pos <= pos_nx;
      phase <= phase_nx;
      enc_a <= phase_nx[0] ^ phase_nx[1];
      enc_b <= phase_nx[1];
      if (we_perd) period <= wval < 24'd2 ? 24'd2 : wval;
      if (we_ctrl) cont_mode <= reg_wdata[1];
      if (we_steps) begin
        dir <= wval[23];
        remaining <= steps_mag;
        timer <= period - 24'd1;
      end else if (abort) remaining <= '0;
      else if (step) begin
        timer <= period - 24'd1;
        remaining <= state == RUN ? remaining - 24'd1 : remaining;
      end else if (busy) timer <= timer - 24'd1;
    end
`ifdef ENC_GEN_INDEX_EN
  always_ff @(posedge sysclk)
    if (reset) enc_i <= 1'b1;
    else enc_i <= pos_nx[IDX_BITS-1:0] == '0;
`else
  assign enc_i = 1'b0;
`endif
endmodule

// File: tb/tb_enc_quad_gen.sv
// tb_enc_quad_gen: register vectors plus scoreboarded quadrature edge timing for enc_quad_gen
module tb_enc_quad_gen;
  logic sysclk = 0, reset = 1, reg_wen = 0;
  logic enc_a, enc_b, enc_i, busy;
  logic [15:0] reg_raddr = 0, reg_waddr = 0;
  logic [31:0] reg_wdata = 0, reg_rdata;
  int total = 0, bad = 0, cyc = 0;
  bit mon = 0;
  typedef struct {logic [1:0] ab; int c; logic bz; logic i;} ev_t;
  typedef struct {logic [15:0] wa; logic [31:0] wd; logic [15:0] ra; logic [31:0] mask; logic [31:0] exp;} vec_t;
  ev_t q[$];
  vec_t tbl[14];
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] mph = 0, prev = 0;
  logic [23:0] mpos = 0;
  localparam logic [31:0] M = 32'hFFFF_FFFB;
`ifdef ENC_GEN_INDEX_EN
  localparam bit INDEX = 1'b1;
`else
  localparam bit INDEX = 1'b0;
`endif
  enc_quad_gen #(.IDX_BITS(2)) dut (
    .sysclk(sysclk), .reset(reset), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
    .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i), .busy(busy)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic idx(input logic [23:0] p);
    return INDEX && p[1:0] == 2'b00;
  endfunction
  task automatic push(input int c, input bit d, input bit bz);
    mph = d ? mph - 2'd1 : mph + 2'd1;
    mpos = d ? mpos - 24'd1 : mpos + 24'd1;
    q.push_back('{ab_tab[mph], c, bz, idx(mpos)});
  endtask
  task automatic push_run(input int w, input int n, input int p, input bit d, input bit cont);
    for (int k = 1; k <= n; k++) push(w + k * p, d, cont || k != n);
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d, output int w);
    @(negedge sysclk);
    reg_waddr = a;
    reg_wdata = d;
    reg_wen = 1;
    @(negedge sysclk);
    reg_wen = 0;
    w = cyc;
  endtask
  task automatic rdchk(input string nm, input logic [15:0] a, input logic [31:0] m, input logic [31:0] exp);
    reg_raddr = a;
    #1;
    chk(nm, reg_rdata & m, exp);
  endtask
  task automatic wait_q(input int n, input int budget, input string nm);
    int k = 0;
    while (q.size() > n && k < budget) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    if (q.size() > n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending edges want %0d", nm, q.size(), n);
      q.delete();
    end
  endtask
  always @(negedge sysclk)
    if (mon && {enc_a, enc_b} !== prev) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_edge: got ab=%b at cyc %0d want no edge", {enc_a, enc_b}, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("edge_ab", {30'd0, enc_a, enc_b}, {30'd0, e.ab});
        chk("edge_cyc", cyc, e.c);
        chk("edge_busy", {31'd0, busy}, {31'd0, e.bz});
        chk("edge_idx", {31'd0, enc_i}, {31'd0, e.i});
      end
      prev = {enc_a, enc_b};
    end
  initial begin
    int w, ws;
    tbl[0]  = '{16'h0050, 32'h0000_0001, 16'h0050, 32'hFFFF_FFFF, 32'h0000_0002};
    tbl[1]  = '{16'h0050, 32'h0000_0000, 16'h0050, 32'hFFFF_FFFF, 32'h0000_0002};
    tbl[2]  = '{16'h0050, 32'h0100_0007, 16'h0050, 32'hFFFF_FFFF, 32'h0000_0007};
    tbl[3]  = '{16'h0050, 32'hFFFF_FFFF, 16'h0050, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    tbl[4]  = '{16'h0053, 32'hFF12_3456, 16'h0053, 32'hFFFF_FFFF, 32'h0012_3456};
    tbl[5]  = '{16'h0063, 32'h0000_0005, 16'h0053, 32'hFFFF_FFFF, 32'h0012_3456};
    tbl[6]  = '{16'h1053, 32'h0000_0009, 16'h0053, 32'hFFFF_FFFF, 32'h0012_3456};
    tbl[7]  = '{16'h0053, 32'h0000_0000, 16'h1053, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[8]  = '{16'h0052, 32'h0000_0002, 16'h0052, M,            32'h0000_0040};
    tbl[9]  = '{16'h0052, 32'h0000_0000, 16'h0052, M,            32'h0000_0000};
    tbl[10] = '{16'h0051, 32'h0000_0000, 16'h0052, M,            32'h0000_0000};
    tbl[11] = '{16'h0050, 32'h0000_0004, 16'h0054, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[12] = '{16'h0050, 32'h0000_0004, 16'h0043, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[13] = '{16'h0050, 32'h0000_0004, 16'h0050, 32'hFFFF_FFFF, 32'h0000_0004};
    repeat (3) @(negedge sysclk);
    reset = 0;
    mon = 1;
    rdchk("rst_perd", 16'h0050, 32'hFFFF_FFFF, 32'd2);
    rdchk("rst_steps", 16'h0051, 32'hFFFF_FFFF, 32'd0);
    rdchk("rst_ctrl", 16'h0052, M, 32'd0);
    rdchk("rst_pos", 16'h0053, 32'hFFFF_FFFF, 32'd0);
    chk("rst_ab_busy", {29'd0, enc_a, enc_b, busy}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      wr(tbl[i].wa, tbl[i].wd, w);
      rdchk($sformatf("reg_vec%0d", i), tbl[i].ra, tbl[i].mask, tbl[i].exp);
    end
    wr(16'h0051, 32'd8, w);
    push_run(w, 8, 4, 0, 0);
    wait_q(0, 60, "fwd8");
    rdchk("fwd8_pos", 16'h0053, 32'hFFFF_FFFF, 32'd8);
    rdchk("fwd8_steps", 16'h0051, 32'hFFFF_FFFF, 32'd0);
    chk("fwd8_busy", {31'd0, busy}, 32'd0);
    wr(16'h0053, 32'd0, w);
    mpos = 0;
    wr(16'h0050, 32'd10, w);
    wr(16'h0051, 32'hFFFF_FFFD, w);
    push_run(w, 3, 10, 1, 0);
    wait_q(0, 60, "rev3");
    rdchk("rev3_pos", 16'h0053, 32'hFFFF_FFFF, 32'h00FF_FFFD);
    rdchk("rev3_ctrl", 16'h0052, M, 32'h0000_002A);
    wr(16'h0050, 32'd1, w);
    rdchk("perd1", 16'h0050, 32'hFFFF_FFFF, 32'd2);
    wr(16'h0051, 32'd2, w);
    push_run(w, 2, 2, 0, 0);
    wait_q(0, 20, "perd_min");
    rdchk("perd_min_pos", 16'h0053, 32'hFFFF_FFFF, 32'h00FF_FFFF);
    wr(16'h0052, 32'd2, w);
    wr(16'h0050, 32'd3, w);
    wr(16'h0051, 32'd1, w);
    push_run(w, 110, 3, 0, 1);
    wait_q(60, 400, "cont_half");
    rdchk("cont_steps", 16'h0051, 32'hFFFF_FFFF, 32'd1);
    chk("cont_busy", {31'd0, busy}, 32'd1);
    wait_q(0, 400, "cont_all");
    wr(16'h0052, 32'd1, w);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rdchk("abort_ctrl", 16'h0052, M, 32'h0000_000A);
    repeat (12) @(negedge sysclk);
    #1;
    chk("abort_frozen", {30'd0, enc_a, enc_b}, 32'b10);
    rdchk("abort_pos", 16'h0053, 32'hFFFF_FFFF, 32'h0000_006D);
    rdchk("abort_steps", 16'h0051, 32'hFFFF_FFFF, 32'd0);
    wr(16'h0050, 32'd20, w);
    wr(16'h0051, 32'd5, ws);
    push(ws + 20, 0, 1);
    push(ws + 40, 0, 1);
    wait_q(0, 100, "mid_first");
    wr(16'h0050, 32'd5, w);
    push(ws + 60, 0, 1);
    push(ws + 65, 0, 1);
    wait_q(0, 100, "mid_second");
    @(negedge sysclk);
    reset = 1;
    mph = 0;
    mpos = 0;
    q.push_back('{2'b00, cyc + 1, 1'b0, idx(24'd0)});
    @(negedge sysclk);
    reset = 0;
    #1;
    wait_q(0, 5, "reset_drop");
    chk("reset_busy_ab", {29'd0, enc_a, enc_b, busy}, 32'd0);
    rdchk("reset_pos", 16'h0053, 32'hFFFF_FFFF, 32'd0);
    rdchk("reset_perd", 16'h0050, 32'hFFFF_FFFF, 32'd2);
    rdchk("reset_steps", 16'h0051, 32'hFFFF_FFFF, 32'd0);
    wr(16'h0051, 32'd8, w);
    push_run(w, 8, 2, 0, 0);
    wait_q(0, 40, "index_run");
    rdchk("index_pos", 16'h0053, 32'hFFFF_FFFF, 32'd8);
    repeat (8) @(negedge sysclk);
    #1;
    chk("quiet_end", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
